uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of the fixed 8N1 receive path in the top-level uart block. Adds configurable frame format, mid-bit sampling with false-start rejection, and parity/framing error detection. Received bytes are buffered in an RX FIFO drained through a valid/ready handshake. Sits between the rx pad, already in the clock domain via an internal synchroniser, and the host-side consumer logic.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 115_200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (868 at defaults), integer division
DATA_BITS, 8, data bits per frame; legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, RX FIFO entries; power of two, 2 or more

Ports:
clock  in  1  system clock; all logic is clocked on its rising edge
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input; idle high
rx_data  out  DATA_BITS  head-of-FIFO data; valid only while rx_valid is high
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts; pop occurs when rx_valid and rx_ready are both high
framing_err  out  1  one-cycle pulse; a stop bit was sampled as 0
parity_err  out  1  one-cycle pulse; parity mismatch
overrun  out  1  one-cycle pulse; a good frame was dropped because the FIFO was full
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: rx_valid=0, framing_err=0, parity_err=0, overrun=0, fifo_count=0, rx_data=0, FSM in IDLE, synchroniser flops=1. Reset mid-frame abandons the frame and empties the FIFO.
- rx passes through a 2-flop synchroniser before use (rx_s). Add 2 cycles of input latency on top of the timing below.
- Bit counter runs 0..CLKS_PER_BIT-1. A bit is sampled when the counter equals CLKS_PER_BIT/2 (mid-bit).
- FSM states:
  - IDLE: on rx_s==0, clear the counter and go to START.
  - START: at mid-bit, if rx_s==1 this is a false start; return to IDLE with no flags. Otherwise go to DATA with the counter restarted so that later samples land at mid-bit.
  - DATA: shift in DATA_BITS samples, LSB first. Then go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample one bit. Odd parity requires the XOR of data and parity bit to be 1; even requires 0.
  - STOP: sample STOP_BITS bits. Any 0 sample pulses framing_err and goes to BREAK_WAIT. Otherwise the frame completes.
  - BREAK_WAIT: stay until rx_s==1, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- Frame completion occurs on the cycle after the last stop-bit mid-sample:
  - parity error: pulse parity_err, drop the byte, return to IDLE.
  - good byte with FIFO not full: push; rx_valid is high on the next cycle if the FIFO was empty (first-word fall-through).
  - good byte with FIFO full and no pop in the same cycle: pulse overrun, leave FIFO contents unchanged, drop the new byte.
  - good byte with FIFO full and a pop in the same cycle: push is accepted, fifo_count is unchanged, no overrun.
- A framing error takes precedence over a parity error; only framing_err pulses.
- The receiver returns to IDLE at the stop-bit mid-sample, so back-to-back frames are accepted with no idle gap.
- Pop with the FIFO empty has no effect. fifo_count never exceeds FIFO_DEPTH or wraps below 0. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit is decided by a 2-of-3 majority over rx_s at counter values mid-1, mid, and mid+1. The decision is taken at mid+1, so bit timing shifts by 1 cycle. A single-cycle glitch at mid-bit does not corrupt the data.
- Undefined: single sample at mid-bit only.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT)
  - function clks_per_bit(clk_freq, baud)
- One sub-module, uart_rx_fifo: parametrised synchronous FIFO (WIDTH, DEPTH), first-word fall-through, push/pop/full/empty/count. The receiver FSM stays in uart_rx_param.

Test Plan:
- Defaults, send 0xA5 then 0x3C 8N1 at 868 clocks/bit, rx_ready=1 -> rx_valid pulses twice with rx_data 0xA5, then 0x3C; no error pulses.
- PARITY=2, send 0xA5 with parity bit 1 (wrong) -> parity_err pulses once, FIFO stays empty; then 0xA5 with parity 0 -> rx_data=0xA5.
- Stop bit driven 0 and held low for 3 bit times, then high -> one framing_err pulse, no push, no spurious frame; next 0x3C received correctly.
- rx low for 200 cycles, then high -> no state change beyond START, no flags, fifo_count=0.
- FIFO_DEPTH=4, rx_ready=0, send 5 bytes 0x01..0x05 -> fifo_count=4, overrun pulses once on 0x05; draining yields 0x01..0x04 in order.
- rst asserted mid-data-bit of 0xA5 with 2 bytes queued -> next cycle fifo_count=0, rx_valid=0; a following 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with parity/framing checks and an RX FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions around mid-bit.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int unsigned CLKS  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned MID   = CLKS / 2;
  localparam int unsigned CNT_W = $clog2(CLKS);
  localparam int unsigned IDX_W = 4;
  localparam parity_e     PAR_MODE = parity_e'(PARITY[1:0]);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  rx_state_e            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_done;
  logic                 r_framing_err;
  logic                 r_parity_err;
  logic                 r_overrun;
  logic                 w_tick;
  logic                 w_bit;
  logic                 w_cnt_last;
  logic                 w_par_ok;
  logic                 w_full;
  logic                 w_empty;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s     = r_sync2;
  assign w_cnt_last = (r_cnt == CNT_W'(CLKS - 1));

`ifdef UART_RX_MAJORITY_EN
  logic r_maj0;
  logic r_maj1;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_maj0 <= 1'b1;
      r_maj1 <= 1'b1;
    end else begin
      if (r_cnt == CNT_W'(MID - 1)) r_maj0 <= w_rx_s;
      if (r_cnt == CNT_W'(MID))     r_maj1 <= w_rx_s;
    end
  end

  assign w_tick = (r_cnt == CNT_W'(MID + 1));
  assign w_bit  = majority3(r_maj0, r_maj1, w_rx_s);
`else
  assign w_tick = (r_cnt == CNT_W'(MID));
  assign w_bit  = w_rx_s;
`endif

  always_comb begin
    w_par_ok = 1'b1;
    case (PAR_MODE)
      PAR_ODD:  w_par_ok = ^{r_shift, r_par_bit};
      PAR_EVEN: w_par_ok = ~^{r_shift, r_par_bit};
      default:  w_par_ok = 1'b1;
    endcase
  end

  // The bit counter free-runs modulo CLKS once a start edge is seen, so each
  // later decision lands exactly one bit period after the start-bit check.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_par_bit     <= 1'b0;
      r_done        <= 1'b0;
      r_framing_err <= 1'b0;
      r_parity_err  <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_framing_err <= 1'b0;
      r_parity_err  <= 1'b0;
      if (r_state != IDLE && r_state != BREAK_WAIT)
        r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);

      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) r_state <= w_bit ? IDLE : DATA;
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            if (r_idx == IDX_W'(DATA_BITS - 1)) begin
              r_idx   <= '0;
              r_state <= (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        uart_pkg::PARITY: begin
          if (w_tick) begin
            r_par_bit <= w_bit;
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (!w_bit) begin
              r_framing_err <= 1'b1;
              r_idx         <= '0;
              r_state       <= BREAK_WAIT;
            end else if (r_idx == IDX_W'(STOP_BITS - 1)) begin
              r_idx   <= '0;
              r_state <= IDLE;
              if (w_par_ok) r_done       <= 1'b1;
              else          r_parity_err <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        BREAK_WAIT: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A full FIFO always holds data, so rx_ready alone means a pop this cycle.
  always_ff @(posedge clock) begin
    if (rst) r_overrun <= 1'b0;
    else     r_overrun <= r_done & w_full & ~rx_ready;
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (rst),
    .i_push  (r_done),
    .i_data  (r_shift),
    .i_pop   (rx_ready),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign rx_valid    = ~w_empty;
  assign framing_err = r_framing_err;
  assign parity_err  = r_parity_err;
  assign overrun     = r_overrun;

endmodule
